// File: rtl/var_clock_divider_pkg.sv
// ---------------------------------------------------------------------------
// clock_divider_pkg
// Shared constants and types for the variable-rate audio sample clock
// divider. The constants are the nominal build values. Each instance can
// override them through its own parameters.
// ---------------------------------------------------------------------------
package clock_divider_pkg;

    localparam int unsigned CNT_W        = 32;    // half-period / counter width
    localparam int unsigned DEFAULT_HALF = 613;   // 27 MHz -> ~22 kHz outclk
    localparam int unsigned STEP         = 16;    // change per speed event
    localparam int unsigned MIN_HALF     = 2;     // fastest legal rate
    localparam int unsigned MAX_HALF     = 4096;  // slowest legal rate

    typedef logic [CNT_W-1:0] half_t;

    // Decoded speed request for one clk cycle
    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_UP    = 2'd1,
        CMD_DOWN  = 2'd2,
        CMD_RESET = 2'd3
    } speed_cmd_e;

endpackage

// File: rtl/rise_detect.sv
// ---------------------------------------------------------------------------
// rise_detect
// Turns a level input into a one-cycle pulse on its rising edge. The history
// flop clears to 0 in reset. A level that is already high when reset is
// released therefore produces one pulse.
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-low reset
//   level  - level input, synchronous to clk
//   pulse  - high for the one cycle where level is 1 and was 0 last cycle
// ---------------------------------------------------------------------------
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_q_r;

    // One-cycle history of the level input
    always_ff @(posedge clk) begin
        if (!reset) begin
            level_q_r <= 1'b0;
        end else begin
            level_q_r <= level;
        end
    end

    assign pulse = level & ~level_q_r;

endmodule

// File: rtl/var_clock_divider.sv
// ---------------------------------------------------------------------------
// var_clock_divider
// Divides clk down to a 50%-duty sample clock for the audio playback path.
// Speed events move the half-period up or down by STEP. The half-period
// saturates at MIN_HALF and MAX_HALF. A speed-reset event restores the
// nominal rate.
// Ports:
//   clk               - system clock, all logic on its rising edge
//   reset             - synchronous, active-low reset
//   speed_up_event    - level; a rising edge shortens the half-period
//   speed_down_event  - level; a rising edge lengthens the half-period
//   speed_reset_event - level; a rising edge restores DEFAULT_HALF
//   outclk            - registered divided clock, period 2*half_period
// ---------------------------------------------------------------------------
module var_clock_divider #(
    parameter int unsigned CNT_W        = clock_divider_pkg::CNT_W,
    parameter int unsigned DEFAULT_HALF = clock_divider_pkg::DEFAULT_HALF,
    parameter int unsigned STEP         = clock_divider_pkg::STEP,
    parameter int unsigned MIN_HALF     = clock_divider_pkg::MIN_HALF,
    parameter int unsigned MAX_HALF     = clock_divider_pkg::MAX_HALF
) (
    input  logic clk,
    input  logic reset,
    input  logic speed_up_event,
    input  logic speed_down_event,
    input  logic speed_reset_event,
    output logic outclk
);

    import clock_divider_pkg::*;

    // Constants widened once so that every compare and add has matched widths
    localparam logic [CNT_W-1:0] DEF_HALF_W = CNT_W'(DEFAULT_HALF);
    localparam logic [CNT_W-1:0] MIN_HALF_W = CNT_W'(MIN_HALF);
    localparam logic [CNT_W-1:0] MAX_HALF_W = CNT_W'(MAX_HALF);
    localparam logic [CNT_W:0]   STEP_EXT   = (CNT_W+1)'(STEP);
    localparam logic [CNT_W:0]   MIN_EXT    = (CNT_W+1)'(MIN_HALF);
    localparam logic [CNT_W:0]   MAX_EXT    = (CNT_W+1)'(MAX_HALF);

    // Reject an illegal parameter set at elaboration (CNT_W below 64)
    if (!((MIN_HALF >= 1) && (MIN_HALF <= DEFAULT_HALF) &&
          (DEFAULT_HALF <= MAX_HALF) &&
          (64'(MAX_HALF) < (64'd1 << CNT_W)))) begin : g_param_error
        $error("var_clock_divider: illegal MIN_HALF/DEFAULT_HALF/MAX_HALF/CNT_W combination");
    end

    logic             up_pulse_s;
    logic             down_pulse_s;
    logic             rst_pulse_s;
    speed_cmd_e       cmd_s;
    logic [CNT_W:0]   half_ext_s;
    logic [CNT_W:0]   dec_s;
    logic [CNT_W:0]   inc_s;
    logic [CNT_W-1:0] half_next_s;
    logic [CNT_W-1:0] half_r;
    logic [CNT_W-1:0] cnt_r;
    logic             phase_end_s;
    logic             outclk_r;

    rise_detect u_rise_up (
        .clk   (clk),
        .reset (reset),
        .level (speed_up_event),
        .pulse (up_pulse_s)
    );

    rise_detect u_rise_down (
        .clk   (clk),
        .reset (reset),
        .level (speed_down_event),
        .pulse (down_pulse_s)
    );

    rise_detect u_rise_reset (
        .clk   (clk),
        .reset (reset),
        .level (speed_reset_event),
        .pulse (rst_pulse_s)
    );

    // Command priority: speed reset first; up and down together cancel out
    always_comb begin
        cmd_s = CMD_NONE;
        if (rst_pulse_s) begin
            cmd_s = CMD_RESET;
        end else if (up_pulse_s && down_pulse_s) begin
            cmd_s = CMD_NONE;
        end else if (up_pulse_s) begin
            cmd_s = CMD_UP;
        end else if (down_pulse_s) begin
            cmd_s = CMD_DOWN;
        end else begin
            cmd_s = CMD_NONE;
        end
    end

    // Next half-period. The math uses one extra bit so that an underflow
    // shows up as the top bit instead of wrapping.
    always_comb begin
        half_ext_s  = {1'b0, half_r};
        dec_s       = half_ext_s - STEP_EXT;
        inc_s       = half_ext_s + STEP_EXT;
        half_next_s = half_r;
        case (cmd_s)
            CMD_RESET: half_next_s = DEF_HALF_W;
            CMD_UP: begin
                if (dec_s[CNT_W] || (dec_s < MIN_EXT)) begin
                    half_next_s = MIN_HALF_W;
                end else begin
                    half_next_s = dec_s[CNT_W-1:0];
                end
            end
            CMD_DOWN: begin
                if (inc_s > MAX_EXT) begin
                    half_next_s = MAX_HALF_W;
                end else begin
                    half_next_s = inc_s[CNT_W-1:0];
                end
            end
            CMD_NONE: half_next_s = half_r;
            default:  half_next_s = half_r;
        endcase
    end

    // Half-period register
    always_ff @(posedge clk) begin
        if (!reset) begin
            half_r <= DEF_HALF_W;
        end else begin
            half_r <= half_next_s;
        end
    end

    // The phase ends at ">=" and not "==". A half-period that shrinks below
    // the running count then ends the phase at once and cannot overrun.
    assign phase_end_s = (cnt_r >= (half_r - CNT_W'(1)));

    // Phase counter and outclk toggle flop
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r    <= '0;
            outclk_r <= 1'b0;
        end else if (phase_end_s) begin
            cnt_r    <= '0;
            outclk_r <= ~outclk_r;
        end else begin
            cnt_r    <= cnt_r + CNT_W'(1);
            outclk_r <= outclk_r;
        end
    end

    assign outclk = outclk_r;

endmodule

// File: tb/tb_var_clock_divider.sv
// ---------------------------------------------------------------------------
// tb_var_clock_divider
// Directed bench for var_clock_divider built with DEFAULT_HALF=8, STEP=2,
// MIN_HALF=2, MAX_HALF=16. The bench measures the half-period as the number
// of clk cycles between outclk toggles. Inputs are driven and outclk is
// sampled on the falling edge of clk.
// ---------------------------------------------------------------------------
module tb_var_clock_divider;

    logic clk               = 1'b0;
    logic reset             = 1'b0;
    logic speed_up_event    = 1'b0;
    logic speed_down_event  = 1'b0;
    logic speed_reset_event = 1'b0;
    logic outclk;

    int total = 0;
    int bad   = 0;

    var_clock_divider #(
        .CNT_W        (32),
        .DEFAULT_HALF (8),
        .STEP         (2),
        .MIN_HALF     (2),
        .MAX_HALF     (16)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .speed_up_event    (speed_up_event),
        .speed_down_event  (speed_down_event),
        .speed_reset_event (speed_reset_event),
        .outclk            (outclk)
    );

    // 37-unit clock period
    always begin
        #18 clk = 1'b1;
        #19 clk = 1'b0;
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Cycles until outclk changes from its present value (bounded)
    task automatic count_phase(output int n);
        logic cur;
        cur = outclk;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((outclk === cur) && (n < 200));
    endtask

    // Skip the phase in progress, then measure one full phase
    task automatic measure_half(output int n);
        int d;
        count_phase(d);
        count_phase(n);
    endtask

    // Cycles from now until outclk reads 1 (bounded)
    task automatic cycles_to_rise(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((outclk !== 1'b1) && (n < 200));
    endtask

    task automatic press(input logic up, input logic down, input logic rst_ev);
        @(negedge clk);
        speed_up_event    = up;
        speed_down_event  = down;
        speed_reset_event = rst_ev;
        @(negedge clk);
        speed_up_event    = 1'b0;
        speed_down_event  = 1'b0;
        speed_reset_event = 1'b0;
    endtask

    initial begin
        int n;
        int exp_sat_up[5]   = '{6, 4, 2, 2, 2};
        int exp_sat_down[6] = '{10, 12, 14, 16, 16, 16};

        // Reset held low for more than 100 time units
        @(negedge clk);
        check("reset_outclk_a", int'(outclk), 0);
        @(negedge clk);
        check("reset_outclk_b", int'(outclk), 0);
        @(negedge clk);
        reset = 1'b1;

        cycles_to_rise(n);
        check("first_rise", n, 8);
        count_phase(n);
        check("nominal_high", n, 8);
        count_phase(n);
        check("nominal_low", n, 8);

        // Up held for three cycles gives a single step
        @(negedge clk);
        speed_up_event = 1'b1;
        repeat (3) @(negedge clk);
        speed_up_event = 1'b0;
        measure_half(n);
        check("up_held_half", n, 6);
        count_phase(n);
        check("up_held_other", n, 6);

        press(1'b0, 1'b0, 1'b1);
        measure_half(n);
        check("speed_reset_a", n, 8);
        press(1'b0, 1'b1, 1'b0);
        measure_half(n);
        check("down_once", n, 10);
        press(1'b0, 1'b0, 1'b1);
        measure_half(n);
        check("speed_reset_b", n, 8);

        // Saturation at the fast end
        foreach (exp_sat_up[i]) begin
            press(1'b1, 1'b0, 1'b0);
            measure_half(n);
            check($sformatf("sat_up_%0d", i), n, exp_sat_up[i]);
        end

        press(1'b0, 1'b0, 1'b1);
        measure_half(n);
        check("speed_reset_c", n, 8);

        // Saturation at the slow end
        foreach (exp_sat_down[i]) begin
            press(1'b0, 1'b1, 1'b0);
            measure_half(n);
            check($sformatf("sat_down_%0d", i), n, exp_sat_down[i]);
        end

        // Simultaneous events
        press(1'b1, 1'b1, 1'b0);
        measure_half(n);
        check("up_down_same", n, 16);
        press(1'b1, 1'b0, 1'b1);
        measure_half(n);
        check("reset_up_same", n, 8);

        repeat (4) press(1'b0, 1'b1, 1'b0);
        measure_half(n);
        check("back_to_16", n, 16);

        // Shrink to 14 while cnt is 12: the phase ends on the next edge
        count_phase(n);
        n = 0;
        repeat (12) begin
            @(negedge clk);
            n++;
        end
        speed_up_event = 1'b1;
        @(negedge clk);
        n++;
        speed_up_event = 1'b0;
        while ((outclk === dut.outclk) && (n < 200) && (n < 14)) begin
            @(negedge clk);
            n++;
        end
        check("shrink_phase", n, 14);
        count_phase(n);
        check("shrink_next", n, 14);

        press(1'b0, 1'b1, 1'b0);
        measure_half(n);
        check("regrow_16", n, 16);

        // Shrink to 8 while cnt is 12: cnt is already past the new end
        count_phase(n);
        n = 0;
        repeat (12) begin
            @(negedge clk);
            n++;
        end
        begin
            logic cur;
            cur = outclk;
            speed_reset_event = 1'b1;
            @(negedge clk);
            n++;
            speed_reset_event = 1'b0;
            while ((outclk === cur) && (n < 200)) begin
                @(negedge clk);
                n++;
            end
        end
        check("overrun_phase", n, 14);
        count_phase(n);
        check("overrun_next", n, 8);

        // Reset in the middle of a high phase
        n = 0;
        while ((outclk !== 1'b1) && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("pre_reset_high", int'(outclk), 1);
        reset            = 1'b0;
        speed_down_event = 1'b1;
        @(negedge clk);
        check("mid_reset_outclk", int'(outclk), 0);
        repeat (2) @(negedge clk);
        check("mid_reset_hold", int'(outclk), 0);

        // Down held high across reset release counts as one step
        reset = 1'b1;
        cycles_to_rise(n);
        check("held_event_rise", n, 10);
        speed_down_event = 1'b0;
        count_phase(n);
        check("held_event_next", n, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
